// File: rtl/mem_sequencer.sv
// Multicycle fetch/decode/data/retire sequencer driving one single-ported RAM; plain instr = fetch_wait+2 cycles, load/store adds data_wait.
// Stalls on ram_ready in IFETCH/DMEM only; a watchdog halts with err after MAX_WAIT unanswered cycles.
module mem_sequencer #(
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] pc_addr,
    input  logic              dcuREN,
    input  logic              dcuWEN,
    input  logic              halt_req,
    input  logic [DATA_W-1:0] dmemaddr,
    input  logic [DATA_W-1:0] dmemstore,
    output logic [DATA_W-1:0] instr,
    output logic              ihit,
    output logic              dhit,
    output logic [DATA_W-1:0] dmemload,
    output logic              pc_en,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [DATA_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic              ram_ready,
    output logic              halted,
    output logic              err,
    output logic [CNT_W-1:0]  retired
);

    localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);

    typedef enum logic [2:0] {
        S_IFETCH,
        S_DECODE,
        S_DMEM,
        S_RETIRE,
        S_HALT
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   instr_q, instr_d;
    logic [DATA_W-1:0]   dmemload_q, dmemload_d;
    logic [CNT_W-1:0]    retired_q, retired_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                op_wr_q, op_wr_d;
    logic                dhit_q, dhit_d;
    logic                err_q, err_d;
    // Set for the first cycle after a reset edge so strobes stay low before fetching resumes.
    logic                quiet_q, quiet_d;

    logic                wd_expired;

    assign wd_expired = (wait_cnt_q == WAIT_W'(MAX_WAIT - 1));

    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        dmemload_d = dmemload_q;
        retired_d  = retired_q;
        wait_cnt_d = wait_cnt_q;
        op_wr_d    = op_wr_q;
        dhit_d     = dhit_q;
        err_d      = err_q;
        quiet_d    = 1'b0;

        case (state_q)
            S_IFETCH: begin
                if (!quiet_q) begin
                    if (ram_ready) begin
                        instr_d = ramload;
                        state_d = S_DECODE;
                    end else if (wd_expired) begin
                        err_d   = 1'b1;
                        state_d = S_HALT;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                end
            end
            S_DECODE: begin
                if (halt_req) begin
                    state_d = S_HALT;
                end else if (dcuWEN) begin
                    op_wr_d    = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = S_DMEM;
                    if (dcuREN) begin
                        err_d = 1'b1;
                    end
                end else if (dcuREN) begin
                    op_wr_d    = 1'b0;
                    wait_cnt_d = '0;
                    state_d    = S_DMEM;
                end else begin
                    state_d = S_RETIRE;
                end
            end
            S_DMEM: begin
                if (ram_ready) begin
                    if (!op_wr_q) begin
                        dmemload_d = ramload;
                    end
                    dhit_d  = 1'b1;
                    state_d = S_RETIRE;
                end else if (wd_expired) begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            S_RETIRE: begin
                retired_d  = retired_q + CNT_W'(1);
                dhit_d     = 1'b0;
                wait_cnt_d = '0;
                state_d    = S_IFETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IFETCH;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IFETCH;
            instr_q    <= '0;
            dmemload_q <= '0;
            retired_q  <= '0;
            wait_cnt_q <= '0;
            op_wr_q    <= 1'b0;
            dhit_q     <= 1'b0;
            err_q      <= 1'b0;
            quiet_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            dmemload_q <= dmemload_d;
            retired_q  <= retired_d;
            wait_cnt_q <= wait_cnt_d;
            op_wr_q    <= op_wr_d;
            dhit_q     <= dhit_d;
            err_q      <= err_d;
            quiet_q    <= quiet_d;
        end
    end

    assign instr    = instr_q;
    assign dmemload = dmemload_q;
    assign retired  = retired_q;
    assign err      = err_q;
    assign ihit     = (state_q == S_DECODE);
    assign pc_en    = (state_q == S_RETIRE);
    assign dhit     = (state_q == S_RETIRE) && dhit_q;
    assign halted   = (state_q == S_HALT);

    assign ramREN   = !quiet_q && ((state_q == S_IFETCH) || ((state_q == S_DMEM) && !op_wr_q));
    assign ramWEN   = !quiet_q && (state_q == S_DMEM) && op_wr_q;
    assign ramaddr  = (state_q == S_IFETCH) ? pc_addr :
                      (state_q == S_DMEM)   ? dmemaddr : '0;
    assign ramstore = (state_q == S_DMEM) ? dmemstore : '0;

endmodule

// File: tb/tb_mem_sequencer.sv
// Directed bench for mem_sequencer: a table of instructions stepped through fetch/decode/data/retire,
// plus hand sequences for counter wrap, HALT, watchdog and reset during a data access.
module tb_mem_sequencer;
    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] pc_addr;
    logic          dcuREN, dcuWEN, halt_req;
    logic [DW-1:0] dmemaddr, dmemstore;
    logic [DW-1:0] instr;
    logic          ihit, dhit, pc_en;
    logic [DW-1:0] dmemload;
    logic          ramREN, ramWEN;
    logic [DW-1:0] ramaddr, ramstore, ramload;
    logic          ram_ready;
    logic          halted, err;
    logic [CW-1:0] retired;

    int n_chk = 0;
    int n_bad = 0;

    mem_sequencer #(.DATA_W(DW), .MAX_WAIT(16), .CNT_W(CW)) dut (
        .CLK(clk), .RST(rst), .pc_addr(pc_addr), .dcuREN(dcuREN), .dcuWEN(dcuWEN),
        .halt_req(halt_req), .dmemaddr(dmemaddr), .dmemstore(dmemstore), .instr(instr),
        .ihit(ihit), .dhit(dhit), .dmemload(dmemload), .pc_en(pc_en), .ramREN(ramREN),
        .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore), .ramload(ramload),
        .ram_ready(ram_ready), .halted(halted), .err(err), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        int          fwait;
        bit          ren;
        bit          wen;
        bit          hlt;
        logic [31:0] daddr;
        logic [31:0] dstore;
        int          dwait;
        logic [31:0] dload;
        logic [31:0] exp_load;
        logic [3:0]  exp_ret;
        bit          exp_err;
    } vec_t;

    vec_t tbl[5];

    task automatic step;
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b", nm, act, exp);
        end
    endtask

    task automatic wait_fetch(output bit ok);
        int n;
        n = 0;
        while (ramREN !== 1'b1 && n < 40) begin
            step;
            n++;
        end
        ok = (ramREN === 1'b1);
        if (!ok) begin
            n_chk++;
            n_bad++;
            $display("FAIL fetch_timeout: ramREN still %b after %0d cycles, expected 1", ramREN, n);
        end
    endtask

    task automatic run_vec(input vec_t v);
        bit ok;
        pc_addr   = v.pc;
        dcuREN    = 1'b0;
        dcuWEN    = 1'b0;
        halt_req  = 1'b0;
        ram_ready = 1'b0;
        ramload   = 32'h0BAD_0BAD;
        dmemaddr  = v.daddr;
        dmemstore = v.dstore;
        #1;
        wait_fetch(ok);
        if (!ok) return;
        chk("fetch_addr", ramaddr, v.pc);
        chk1("fetch_wen", ramWEN, 1'b0);
        repeat (v.fwait) step;
        ram_ready = 1'b1;
        ramload   = v.ins;
        step;
        ram_ready = 1'b0;
        ramload   = 32'h0BAD_0BAD;
        chk1("decode_ihit", ihit, 1'b1);
        chk("decode_instr", instr, v.ins);
        chk1("decode_ren_idle", ramREN, 1'b0);
        dcuREN   = v.ren;
        dcuWEN   = v.wen;
        halt_req = v.hlt;
        step;
        dcuREN   = 1'b0;
        dcuWEN   = 1'b0;
        halt_req = 1'b0;
        chk1("ihit_pulse", ihit, 1'b0);
        if (v.hlt) begin
            chk1("halted", halted, 1'b1);
            return;
        end
        if (v.ren || v.wen) begin
            chk1("dmem_wen", ramWEN, v.wen);
            chk1("dmem_ren", ramREN, ~v.wen);
            chk("dmem_addr", ramaddr, v.daddr);
            if (v.wen) chk("dmem_store", ramstore, v.dstore);
            repeat (v.dwait) step;
            ramload   = v.dload;
            ram_ready = 1'b1;
            step;
            ram_ready = 1'b0;
            ramload   = 32'h0BAD_0BAD;
        end
        chk1("retire_pc_en", pc_en, 1'b1);
        chk1("retire_dhit", dhit, v.ren || v.wen);
        chk("retire_dmemload", dmemload, v.exp_load);
        chk1("retire_err", err, v.exp_err);
        chk("retire_instr_hold", instr, v.ins);
        step;
        chk1("pc_en_pulse", pc_en, 1'b0);
        chk1("dhit_pulse", dhit, 1'b0);
        chk("retired", 32'(retired), 32'(v.exp_ret));
        chk1("next_fetch", ramREN, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t v;
        bit   ok;
        tbl[0] = '{32'h0,  32'h3421_00FF, 2, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,    0, 32'h0,         32'h0,         4'd1, 1'b0};
        tbl[1] = '{32'h4,  32'h8C01_0080, 0, 1'b1, 1'b0, 1'b0, 32'h80,  32'h0,    1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'd2, 1'b0};
        tbl[2] = '{32'h8,  32'hAC02_0040, 1, 1'b0, 1'b1, 1'b0, 32'h40,  32'h1234, 0, 32'h5555_5555, 32'hDEAD_BEEF, 4'd3, 1'b0};
        tbl[3] = '{32'hC,  32'h8C03_0100, 3, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0,    3, 32'h0000_00A5, 32'h0000_00A5, 4'd4, 1'b0};
        tbl[4] = '{32'h10, 32'hFC04_0044, 0, 1'b1, 1'b1, 1'b0, 32'h44,  32'hCAFE, 2, 32'h1111,      32'h0000_00A5, 4'd5, 1'b1};

        rst = 1'b1; pc_addr = '0; dcuREN = 1'b0; dcuWEN = 1'b0; halt_req = 1'b0;
        dmemaddr = '0; dmemstore = '0; ramload = '0; ram_ready = 1'b0;
        step; step;
        rst = 1'b0;
        #1;
        chk("rst_retired", 32'(retired), 32'd0);
        chk1("rst_err", err, 1'b0);
        chk1("rst_halted", halted, 1'b0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_dmemload", dmemload, 32'h0);
        chk1("rst_ihit", ihit, 1'b0);
        chk1("rst_pc_en", pc_en, 1'b0);
        chk1("rst_dhit", dhit, 1'b0);

        for (int i = 0; i < 5; i++) run_vec(tbl[i]);

        // Twelve plain instructions walk the 4-bit counter from 5 through the wrap to 1.
        for (int i = 0; i < 12; i++) begin
            v = '{32'h20 + 32'(4 * i), 32'h0000_0020 + 32'(i), i % 3, 1'b0, 1'b0, 1'b0,
                  32'h0, 32'h0, 0, 32'h0, 32'h0000_00A5, 4'(6 + i), 1'b1};
            run_vec(v);
        end

        v = '{32'h80, 32'hFC00_0000, 1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 0, 32'h0, 32'h0, 4'd1, 1'b1};
        run_vec(v);
        ram_ready = 1'b1;
        repeat (3) step;
        ram_ready = 1'b0;
        chk1("halt_absorb", halted, 1'b1);
        chk("halt_retired_frozen", 32'(retired), 32'd1);
        chk1("halt_ren", ramREN, 1'b0);
        chk1("halt_wen", ramWEN, 1'b0);
        chk1("halt_pc_en", pc_en, 1'b0);

        // Watchdog: fetch never answered.
        rst = 1'b1; step; step; rst = 1'b0;
        pc_addr = 32'h200;
        step;
        chk1("wd_fetch_start", ramREN, 1'b1);
        chk1("wd_err_clear", err, 1'b0);
        repeat (15) step;
        chk1("wd_cycle15_halted", halted, 1'b0);
        chk1("wd_cycle15_ren", ramREN, 1'b1);
        step;
        chk1("wd_halted", halted, 1'b1);
        chk1("wd_err", err, 1'b1);
        chk1("wd_ren_off", ramREN, 1'b0);
        ram_ready = 1'b1;
        step;
        ram_ready = 1'b0;
        chk1("wd_stays_halted", halted, 1'b1);
        chk("wd_no_retire", 32'(retired), 32'd0);

        // Reset while a store is in progress.
        rst = 1'b1; step; rst = 1'b0; step;
        run_vec(tbl[0]);
        pc_addr = 32'h4;
        #1;
        wait_fetch(ok);
        ram_ready = 1'b1;
        ramload   = 32'hAC05_0010;
        step;
        ram_ready = 1'b0;
        dcuWEN    = 1'b1;
        dmemaddr  = 32'h10;
        dmemstore = 32'h77;
        step;
        dcuWEN = 1'b0;
        chk1("mid_dmem_wen", ramWEN, 1'b1);
        rst = 1'b1;
        step;
        chk1("rst_mid_wen", ramWEN, 1'b0);
        chk1("rst_mid_ren", ramREN, 1'b0);
        chk1("rst_mid_pc_en", pc_en, 1'b0);
        chk("rst_mid_retired", 32'(retired), 32'd0);
        rst = 1'b0;
        step;
        chk1("rst_mid_refetch", ramREN, 1'b1);
        chk("rst_mid_refetch_addr", ramaddr, 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end
endmodule
